alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: ALU with one registered output stage and valid/ready handshakes on both sides.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier on opcode 9.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;
    logic             r_outValid;

    logic             w_idle;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluCarry;
    logic             w_aluOvf;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    state_t             r_state;
    logic [SHW-1:0]     r_mulCnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_prodNext;

    assign w_idle     = (r_state == IDLE);
    assign w_prodNext = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
`else
    assign w_idle = 1'b1;
`endif

    // A new op may enter whenever the output slot is empty or is being drained this cycle.
    assign in_ready = !rst && w_idle && (!r_outValid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_aluResult = '0;
        w_aluCarry  = 1'b0;
        w_aluOvf    = 1'b0;
        case (opcode)
            4'd0: w_aluResult = a | b;
            4'd1: w_aluResult = ~(a | b);
            4'd2: w_aluResult = a ^ b;
            4'd3: w_aluResult = a & b;
            4'd4: w_aluResult = ~(a & b);
            4'd5: begin
                w_aluResult = w_sum[WIDTH-1:0];
                w_aluCarry  = w_sum[WIDTH];
                w_aluOvf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            // The extra top bit of the difference is the unsigned borrow.
            4'd6: begin
                w_aluResult = w_diff[WIDTH-1:0];
                w_aluCarry  = w_diff[WIDTH];
                w_aluOvf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd7:    w_aluResult = a >> w_shamt;
            4'd8:    w_aluResult = a << w_shamt;
            default: w_aluResult = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
`ifdef ALU_PIPE_MUL_EN
            r_state    <= IDLE;
            r_mulCnt   <= '0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_mplier   <= '0;
`endif
        end else begin
            if (w_accept) begin
`ifdef ALU_PIPE_MUL_EN
                // Multiply consumes the output slot only when it finishes.
                if (opcode == 4'd9) begin
                    r_state    <= MUL_BUSY;
                    r_mulCnt   <= '0;
                    r_mcand    <= {{WIDTH{1'b0}}, a};
                    r_mplier   <= b;
                    r_prod     <= '0;
                    r_outValid <= 1'b0;
                end else begin
`endif
                    r_result   <= w_aluResult;
                    r_flags    <= {w_aluCarry, w_aluOvf, (w_aluResult == '0)};
                    r_outValid <= 1'b1;
`ifdef ALU_PIPE_MUL_EN
                end
`endif
            end
`ifdef ALU_PIPE_MUL_EN
            else if (r_state == MUL_BUSY) begin
                r_prod   <= w_prodNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_mulCnt <= r_mulCnt + SHW'(1);
                // The final partial product goes straight into the output register.
                if (r_mulCnt == LAST_ITER) begin
                    r_state    <= IDLE;
                    r_mulCnt   <= '0;
                    r_result   <= w_prodNext[WIDTH-1:0];
                    r_flags    <= {(|w_prodNext[2*WIDTH-1:WIDTH]), 1'b0,
                                   (w_prodNext[WIDTH-1:0] == '0)};
                    r_outValid <= 1'b1;
                end
            end
`endif
            else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven vectors and hand-written handshake/multiply sequences for alu_pipe,
// with a scoreboard queue checked whenever an output handshake occurs.
module tb_alu_pipe;

    localparam int WIDTH = 8;
    localparam int NVEC  = 17;

`ifdef ALU_PIPE_MUL_EN
    localparam int       EXP_LAT  = WIDTH + 1;
    localparam int       EXP_BUSY = WIDTH;
    localparam logic [7:0] MUL_RES = 8'h43;
    localparam logic [2:0] MUL_FLG = 3'b100;
`else
    localparam int       EXP_LAT  = 1;
    localparam int       EXP_BUSY = 0;
    localparam logic [7:0] MUL_RES = 8'h00;
    localparam logic [2:0] MUL_FLG = 3'b001;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [3:0]       opcode = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    typedef struct {
        logic [3:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] res;
        logic [2:0] flg;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [2:0] flg;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sbQ[$];
    int   assertions = 0;
    int   failures = 0;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [7:0] res, input logic [2:0] flg);
        exp_t e;
        e.res = res;
        e.flg = flg;
        sbQ.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                                 input logic [7:0] res, input logic [2:0] flg);
        int n;
        opcode   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            assertions++;
            failures++;
            $display("[TB] FAIL accept_timeout: op %0d not accepted within 50 cycles", op);
        end else begin
            pushExpected(res, flg);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    // Scoreboard: every output handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected_output: got result 0x%0h with empty scoreboard", result);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("sb_result", 32'(result), 32'(e.res));
                checkOutput("sb_flags", 32'(flags), 32'(e.flg));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int busy;
        int seen;

        vecs[0]  = '{4'd0,  8'hA5, 8'h0F, 8'hAF, 3'b000};
        vecs[1]  = '{4'd1,  8'hA5, 8'h0F, 8'h50, 3'b000};
        vecs[2]  = '{4'd1,  8'hFF, 8'h00, 8'h00, 3'b001};
        vecs[3]  = '{4'd2,  8'hAA, 8'hFF, 8'h55, 3'b000};
        vecs[4]  = '{4'd3,  8'hF0, 8'h3C, 8'h30, 3'b000};
        vecs[5]  = '{4'd4,  8'hF0, 8'h3C, 8'hCF, 3'b000};
        vecs[6]  = '{4'd5,  8'hF0, 8'h20, 8'h10, 3'b100};
        vecs[7]  = '{4'd5,  8'h7F, 8'h01, 8'h80, 3'b010};
        vecs[8]  = '{4'd5,  8'hFF, 8'h01, 8'h00, 3'b101};
        vecs[9]  = '{4'd6,  8'h80, 8'h01, 8'h7F, 3'b010};
        vecs[10] = '{4'd6,  8'h05, 8'h05, 8'h00, 3'b001};
        vecs[11] = '{4'd6,  8'h03, 8'h05, 8'hFE, 3'b100};
        vecs[12] = '{4'd7,  8'h96, 8'h03, 8'h12, 3'b000};
        vecs[13] = '{4'd8,  8'h96, 8'h0B, 8'hB0, 3'b000};
        vecs[14] = '{4'd7,  8'h80, 8'hFF, 8'h01, 3'b000};
        vecs[15] = '{4'd10, 8'hFF, 8'hFF, 8'h00, 3'b001};
        vecs[16] = '{4'd15, 8'h12, 8'h34, 8'h00, 3'b001};

        // Reset state, with a request pending to show in_ready is held low.
        in_valid = 1'b1;
        opcode   = 4'd5;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] table vectors, back-to-back");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].flg);
        end
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] shift pair, one op per cycle");
        opcode = 4'd7; a = 8'h96; b = 8'h03; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_ready_first", 32'(in_ready), 32'd1);
        pushExpected(8'h12, 3'b000);
        @(posedge clk);
        #1;
        opcode = 4'd8; a = 8'h96; b = 8'h0B;
        @(negedge clk);
        checkOutput("b2b_ready_second", 32'(in_ready), 32'd1);
        checkOutput("b2b_first_result", 32'(result), 32'h12);
        pushExpected(8'hB0, 3'b000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_second_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_second_result", 32'(result), 32'hB0);
        @(posedge clk);
        #1;

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        opcode = 4'd2; a = 8'hAA; b = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept_ready", 32'(in_ready), 32'd1);
        pushExpected(8'h55, 3'b000);
        @(posedge clk);
        #1;
        opcode = 4'd5; a = 8'h01; b = 8'h01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_result", 32'(result), 32'h55);
            checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
            a = 8'(c + 2);
            @(posedge clk);
            #1;
            a = 8'h01;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        pushExpected(8'h02, 3'b000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_replace_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] opcode 9 latency and busy window");
        opcode = 4'd9; a = 8'h13; b = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("mul_accept_ready", 32'(in_ready), 32'd1);
        pushExpected(MUL_RES, MUL_FLG);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        busy = 0;
        for (int n = 1; n <= 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            opcode = 4'($urandom);
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            if (!in_ready) busy++;
        end
        checkOutput("mul_latency", 32'(lat), 32'(EXP_LAT));
        checkOutput("mul_busy_cycles", 32'(busy), 32'(EXP_BUSY));
        @(posedge clk);
        #1;

        $display("[TB] reset during opcode 9");
        opcode = 4'd9; a = 8'h13; b = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("mulrst_accept_ready", 32'(in_ready), 32'd1);
`ifndef ALU_PIPE_MUL_EN
        pushExpected(MUL_RES, MUL_FLG);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("mulrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mulrst_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        seen = 0;
        for (int n = 0; n < WIDTH + 4; n++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("mulrst_no_output", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'd5, 8'h01, 8'h01, 8'h02, 3'b000);

        for (int n = 0; n < 20 && sbQ.size() != 0; n++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
